// File: rtl/prim_ser_tx.sv
// prim_ser_tx: serializes one IN_WIDTH word into BEATS OUT_WIDTH beats on a valid/ready/stall stream.
// Build option PRIM_SER_TX_MSB_FIRST_EN sends the MSB slice first; default sends the LSB slice first.
//
// state | meaning
// IDLE  | nothing held, ready for a new word
// SEND  | word in hold, beat cnt presented on ddat_o until it transfers
module prim_ser_tx #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 urdy_o,
    input  logic                 uvld_i,
    input  logic [IN_WIDTH-1:0]  udat_i,
    input  logic                 dstall_i,
    input  logic                 drdy_i,
    output logic                 dvld_o,
    output logic [OUT_WIDTH-1:0] ddat_o,
    output logic                 dlast_o
);
    localparam int BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [BEATS-1:0][OUT_WIDTH-1:0] hold;
    logic [CNT_W-1:0]                cnt;
    logic [CNT_W-1:0]                beat_idx;
    logic                            is_last;
    logic                            transfer;
    logic                            accept;
    logic                            advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (transfer && is_last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // urdy_o also opens on the final transfer so the next word follows without a bubble
    always_comb begin
        is_last  = (state == SEND) && (cnt == LAST_CNT);
        dvld_o   = (state == SEND) && !dstall_i;
        transfer = dvld_o && drdy_i;
        urdy_o   = !reset && ((state == IDLE) || (transfer && is_last));
        accept   = urdy_o && uvld_i;
        advance  = transfer && !is_last;
        dlast_o  = is_last;
        ddat_o   = hold[beat_idx];
    end

`ifdef PRIM_SER_TX_MSB_FIRST_EN
    assign beat_idx = LAST_CNT - cnt;
`else
    assign beat_idx = cnt;
`endif

    // cnt and hold only move on accept or transfer, so a stalled beat stays put
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
            cnt  <= '0;
        end else if (accept) begin
            hold <= udat_i;
            cnt  <= '0;
        end else if (advance) begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prim_ser_tx.sv
// Self-checking bench for prim_ser_tx: queue-of-beats reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_prim_ser_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        urdy_o;
    logic        uvld_i;
    logic [63:0] udat_i;
    logic        dstall_i;
    logic        drdy_i;
    logic        dvld_o;
    logic [15:0] ddat_o;
    logic        dlast_o;

    prim_ser_tx #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .urdy_o  (urdy_o),
        .uvld_i  (uvld_i),
        .udat_i  (udat_i),
        .dstall_i(dstall_i),
        .drdy_i  (drdy_i),
        .dvld_o  (dvld_o),
        .ddat_o  (ddat_o),
        .dlast_o (dlast_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int urdy_busy_cnt = 0;
    bit acc_flag = 1'b0;

    logic [15:0] q_dat[$];
    bit          q_last[$];
    logic [15:0] xfer_dat[$];
    bit          xfer_last[$];
    int          xfer_cyc[$];
    int          acc_cyc[$];

    localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] W2 = 64'h8888_7777_6666_5555;
    localparam logic [63:0] W3 = 64'hDDDD_CCCC_BBBB_AAAA;
    logic [15:0] exp_sw[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        int idx;
        for (int k = 0; k < 4; k++) begin
`ifdef PRIM_SER_TX_MSB_FIRST_EN
            idx = 3 - k;
`else
            idx = k;
`endif
            q_dat.push_back(w[idx*16 +: 16]);
            q_last.push_back(k == 3);
        end
    endtask

    // Reference model and per-cycle compare, sampled mid-cycle while inputs are stable
    always @(negedge clk) begin : cmp
        bit busy, e_dvld, e_last, e_urdy, xfer, acc;
        cyc++;
        acc_flag = 1'b0;
        if (reset) begin
            q_dat.delete();
            q_last.delete();
            chk("rst_urdy", urdy_o, 0);
            chk("rst_dvld", dvld_o, 0);
            chk("rst_dlast", dlast_o, 0);
            chk("rst_ddat", ddat_o, 0);
        end else begin
            busy   = q_dat.size() > 0;
            e_dvld = busy && !dstall_i;
            xfer   = e_dvld && drdy_i;
            e_last = busy && q_last[0];
            e_urdy = !busy || (xfer && e_last);
            acc    = e_urdy && uvld_i;
            chk("dvld", dvld_o, e_dvld);
            chk("dlast", dlast_o, e_last);
            chk("urdy", urdy_o, e_urdy);
            if (busy) chk("ddat", ddat_o, q_dat[0]);
            if (busy && urdy_o) urdy_busy_cnt++;
            if (xfer) begin
                xfer_dat.push_back(ddat_o);
                xfer_last.push_back(dlast_o);
                xfer_cyc.push_back(cyc);
                void'(q_dat.pop_front());
                void'(q_last.pop_front());
            end
            if (acc) begin
                push_word(udat_i);
                acc_cyc.push_back(cyc);
            end
            acc_flag = acc;
        end
    end

    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        if (rnd) begin
            drdy_i   = ($urandom_range(0, 3) != 0);
            dstall_i = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic clear_log();
        xfer_dat.delete();
        xfer_last.delete();
        xfer_cyc.delete();
        acc_cyc.delete();
        urdy_busy_cnt = 0;
    endtask

    // Holds the word valid until accepted; leaves uvld_i high on return
    task automatic send_word(input logic [63:0] w, input bit rnd);
        bit done;
        done   = 1'b0;
        uvld_i = 1'b1;
        udat_i = w;
        for (int n = 0; n < 300 && !done; n++) begin
            step(rnd);
            done = acc_flag;
        end
        chk("accept_timeout", done, 1);
    endtask

    task automatic wait_idle(input int maxc);
        for (int n = 0; n < maxc && q_dat.size() != 0; n++) step(0);
        chk("idle_timeout", q_dat.size() == 0, 1);
    endtask

    task automatic wait_xfers(input int cnt_req, input int maxc);
        for (int n = 0; n < maxc && xfer_dat.size() < cnt_req; n++) step(0);
        chk("xfer_timeout", xfer_dat.size() >= cnt_req, 1);
    endtask

    initial begin
`ifdef PRIM_SER_TX_MSB_FIRST_EN
        exp_sw = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
`else
        exp_sw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`endif
        reset    = 1'b1;
        uvld_i   = 1'b0;
        udat_i   = '0;
        drdy_i   = 1'b1;
        dstall_i = 1'b0;

        // reset and idle
        repeat (3) step(0);
        chk("rst_hold_urdy", urdy_o, 0);
        chk("rst_hold_dvld", dvld_o, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_urdy", urdy_o, 1);
        chk("post_rst_dvld", dvld_o, 0);
        clear_log();
        repeat (5) step(0);
        chk("idle_no_beats", xfer_dat.size(), 0);

        // single word
        clear_log();
        send_word(W1, 0);
        uvld_i = 1'b0;
        wait_idle(50);
        chk("sw_count", xfer_dat.size(), 4);
        if (xfer_dat.size() == 4 && acc_cyc.size() == 1) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sw_beat%0d", i), xfer_dat[i], exp_sw[i]);
                chk($sformatf("sw_last%0d", i), xfer_last[i], i == 3);
                chk($sformatf("sw_cyc%0d", i), xfer_cyc[i], acc_cyc[0] + 1 + i);
            end
        end

        // back-to-back
        clear_log();
        send_word(W2, 0);
        send_word(W3, 0);
        uvld_i = 1'b0;
        wait_idle(50);
        chk("b2b_count", xfer_dat.size(), 8);
        chk("b2b_urdy_busy", urdy_busy_cnt, 2);
        if (xfer_dat.size() == 8) begin
            for (int i = 1; i < 8; i++)
                chk($sformatf("b2b_cyc%0d", i), xfer_cyc[i], xfer_cyc[0] + i);
`ifdef PRIM_SER_TX_MSB_FIRST_EN
            chk("b2b_beat4", xfer_dat[4], 16'hDDDD);
`else
            chk("b2b_beat4", xfer_dat[4], 16'hAAAA);
`endif
        end

        // backpressure on beat 2
        clear_log();
        send_word(W1, 0);
        uvld_i = 1'b0;
        wait_xfers(2, 50);
        drdy_i = 1'b0;
        repeat (5) begin
            step(0);
            chk("bp_ddat", ddat_o, exp_sw[2]);
            chk("bp_dvld", dvld_o, 1);
        end
        drdy_i = 1'b1;
        wait_idle(50);
        chk("bp_count", xfer_dat.size(), 4);
        if (xfer_dat.size() == 4) begin
            chk("bp_beat2", xfer_dat[2], exp_sw[2]);
            chk("bp_gap", xfer_cyc[2] - xfer_cyc[1], 6);
        end

        // stall with drdy high
        clear_log();
        send_word(W1, 0);
        uvld_i = 1'b0;
        wait_xfers(1, 50);
        dstall_i = 1'b1;
        repeat (3) begin
            step(0);
            chk("st_dvld", dvld_o, 0);
            chk("st_ddat", ddat_o, exp_sw[1]);
        end
        dstall_i = 1'b0;
        wait_idle(50);
        chk("st_count", xfer_dat.size(), 4);
        if (xfer_dat.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("st_beat%0d", i), xfer_dat[i], exp_sw[i]);

        // reset mid-word
        clear_log();
        send_word(W2, 0);
        uvld_i = 1'b0;
        wait_xfers(2, 50);
        reset = 1'b1;
        #1;
        chk("mr_dvld", dvld_o, 0);
        chk("mr_urdy", urdy_o, 0);
        repeat (2) step(0);
        reset = 1'b0;
        clear_log();
        send_word(W1, 0);
        uvld_i = 1'b0;
        wait_idle(50);
        chk("mr_count", xfer_dat.size(), 4);
        if (xfer_dat.size() == 4) chk("mr_first", xfer_dat[0], exp_sw[0]);

        // randomized traffic
        clear_log();
        for (int w = 0; w < 200; w++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                uvld_i = 1'b0;
                repeat (gap) step(1);
            end
            send_word({$urandom, $urandom}, 1);
        end
        uvld_i   = 1'b0;
        drdy_i   = 1'b1;
        dstall_i = 1'b0;
        wait_idle(100);
        chk("rnd_count", xfer_dat.size(), 800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
